// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between pipe_ctrl and the datapath: hazard/MDU/exception inputs,
// enable/clear strobes out. Perf counter signals exist only with PIPE_CTRL_PERF_EN.
interface pipe_ctrl_if;
  logic hz_stall;
  logic D_md_use;
  logic E_md_start;
  logic E_md_div;
  logic D_eret;
  logic Req;
  logic PC_en;
  logic FD_en;
  logic DE_en;
  logic EM_en;
  logic MW_en;
  logic FD_reset;
  logic DE_reset;
  logic EM_reset;
  logic MW_reset;
  logic npc_epc;
  logic md_busy;
  logic eret_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output hz_stall, D_md_use, E_md_start, E_md_div, D_eret, Req,
    input  PC_en, FD_en, DE_en, EM_en, MW_en, FD_reset, DE_reset, EM_reset, MW_reset,
    input  npc_epc, md_busy, eret_state, stall_cnt, flush_cnt
  );
  modport slave (
    input  hz_stall, D_md_use, E_md_start, E_md_div, D_eret, Req,
    output PC_en, FD_en, DE_en, EM_en, MW_en, FD_reset, DE_reset, EM_reset, MW_reset,
    output npc_epc, md_busy, eret_state, stall_cnt, flush_cnt
  );
`else
  modport master (
    output hz_stall, D_md_use, E_md_start, E_md_div, D_eret, Req,
    input  PC_en, FD_en, DE_en, EM_en, MW_en, FD_reset, DE_reset, EM_reset, MW_reset,
    input  npc_epc, md_busy, eret_state
  );
  modport slave (
    input  hz_stall, D_md_use, E_md_start, E_md_div, D_eret, Req,
    output PC_en, FD_en, DE_en, EM_en, MW_en, FD_reset, DE_reset, EM_reset, MW_reset,
    output npc_epc, md_busy, eret_state
  );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall/flush arbitration, MDU busy timer and eret redirect.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input logic       clk,
  input logic       reset,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StRun, StEretFlush} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
  logic               md_busy;
  logic               stall;
  logic               eret_take;

  assign md_busy = (md_cnt_q != '0);
  assign stall   = bus.hz_stall | (bus.D_md_use & (md_busy | bus.E_md_start));

  // A pending exception suppresses a same-cycle MDU start but never aborts a running count.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (bus.E_md_start && !bus.Req) begin
      md_cnt_d = bus.E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  assign eret_take = bus.D_eret && !bus.Req && !stall && (state_q == StRun);

  always_comb begin
    state_d = StRun;
    if (eret_take) state_d = StEretFlush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StRun;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    bus.PC_en    = 1'b1;
    bus.FD_en    = 1'b1;
    bus.DE_en    = 1'b1;
    bus.EM_en    = 1'b1;
    bus.MW_en    = 1'b1;
    bus.FD_reset = 1'b0;
    bus.DE_reset = 1'b0;
    bus.EM_reset = 1'b0;
    bus.MW_reset = 1'b0;
    bus.npc_epc  = 1'b0;
    // Strobes stay at their pass-through values for as long as reset is held.
    if (!reset) begin
      bus.npc_epc = 1'b0;
    end else if (bus.Req) begin
      bus.FD_reset = 1'b1;
      bus.DE_reset = 1'b1;
      bus.EM_reset = 1'b1;
      bus.MW_reset = 1'b1;
    end else if (stall) begin
      bus.PC_en    = 1'b0;
      bus.FD_en    = 1'b0;
      bus.DE_reset = 1'b1;
    end else if (state_q == StEretFlush) begin
      bus.FD_reset = 1'b1;
    end else if (bus.D_eret) begin
      bus.npc_epc = 1'b1;
    end
  end

  assign bus.md_busy    = md_busy;
  assign bus.eret_state = (state_q == StEretFlush);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !bus.Req) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.Req || (state_q == StEretFlush)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, corner sequences and a
// randomized run against a cycle-indexed reference model.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: absolute cycle index, end of MDU busy window, cycle of eret flush.
  int          cyc;
  int          busy_until;
  int          flush_cyc;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_flush_cnt;
  logic [11:0] last_out;

  typedef struct {
    logic hz, mu, st, dv, er, rq;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [11:0] got();
    return {bus.PC_en, bus.FD_en, bus.DE_en, bus.EM_en, bus.MW_en,
            bus.FD_reset, bus.DE_reset, bus.EM_reset, bus.MW_reset,
            bus.npc_epc, bus.md_busy, bus.eret_state};
  endfunction

  function automatic logic [11:0] model_out(logic hz, logic mu, logic st, logic er, logic rq);
    logic busy, flush, stl;
    busy = (cyc < busy_until);
    flush = (cyc == flush_cyc);
    stl = hz | (mu & (busy | st));
    if (rq)    return {5'b11111, 4'b1111, 1'b0, busy, flush};
    if (stl)   return {5'b00111, 4'b0100, 1'b0, busy, flush};
    if (flush) return {5'b11111, 4'b1000, 1'b0, busy, flush};
    if (er)    return {5'b11111, 4'b0000, 1'b1, busy, flush};
    return {5'b11111, 4'b0000, 1'b0, busy, flush};
  endfunction

  task automatic model_edge(input logic hz, mu, st, dv, er, rq);
    logic busy, flush, stl;
    busy = (cyc < busy_until);
    flush = (cyc == flush_cyc);
    stl = hz | (mu & (busy | st));
    if (stl && !rq) m_stall_cnt = m_stall_cnt + 1;
    if (rq || flush) m_flush_cnt = m_flush_cnt + 1;
    cyc = cyc + 1;
    if (st && !rq) busy_until = cyc + (dv ? 10 : 5);
    if (er && !rq && !stl && !flush) flush_cyc = cyc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic hz, mu, st, dv, er, rq);
    bus.hz_stall   = hz;
    bus.D_md_use   = mu;
    bus.E_md_start = st;
    bus.E_md_div   = dv;
    bus.D_eret     = er;
    bus.Req        = rq;
  endtask

  task automatic model_reset();
    cyc = 0;
    busy_until = 0;
    flush_cyc = -1;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("in_reset_outputs", 32'(got()), 32'(12'b111110000000));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic hz, mu, st, dv, er, rq);
    @(negedge clk);
    drive(hz, mu, st, dv, er, rq);
    #1;
    last_out = got();
    check("outputs", 32'(last_out), 32'(model_out(hz, mu, st, er, rq)));
`ifdef PIPE_CTRL_PERF_EN
    check("stall_cnt", bus.stall_cnt, m_stall_cnt);
    check("flush_cnt", bus.flush_cnt, m_flush_cnt);
`endif
    @(posedge clk);
    model_edge(hz, mu, st, dv, er, rq);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    last_out = '0;

    //            hz mu st dv er rq   PC FD DE EM MW FDr DEr EMr MWr npc busy est
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 12'b111110000000};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 12'b001110100000};
    vecs[2]  = '{0, 0, 0, 0, 1, 0, 12'b111110000100};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 12'b111111000001};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 12'b111110000000};
    vecs[5]  = '{0, 1, 1, 0, 0, 0, 12'b001110100000};
    vecs[6]  = '{0, 1, 0, 0, 0, 0, 12'b001110100010};
    vecs[7]  = '{0, 1, 0, 0, 0, 0, 12'b001110100010};
    vecs[8]  = '{0, 1, 0, 0, 0, 0, 12'b001110100010};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 12'b001110100010};
    vecs[10] = '{0, 1, 0, 0, 0, 0, 12'b001110100010};
    vecs[11] = '{0, 1, 0, 0, 0, 0, 12'b111110000000};
    vecs[12] = '{1, 0, 1, 0, 0, 1, 12'b111111111000};
    vecs[13] = '{0, 1, 0, 0, 0, 0, 12'b111110000000};
    vecs[14] = '{1, 0, 0, 0, 1, 0, 12'b001110100000};
    vecs[15] = '{0, 0, 0, 0, 1, 0, 12'b111110000100};
    vecs[16] = '{0, 0, 0, 0, 0, 1, 12'b111111111001};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 12'b111110000000};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].hz, vecs[i].mu, vecs[i].st, vecs[i].dv, vecs[i].er, vecs[i].rq);
      #1;
      check($sformatf("vec%0d", i), 32'(got()), 32'(vecs[i].exp));
      @(posedge clk);
      model_edge(vecs[i].hz, vecs[i].mu, vecs[i].st, vecs[i].dv, vecs[i].er, vecs[i].rq);
    end

    // Divide busy window length, bounded.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (!last_out[1]) break;
      n++;
    end
    check("div_busy_len", n, 10);

    // Req arriving with three cycles left must not cut the count short.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n = last_out[1] ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (!last_out[1]) break;
      n++;
    end
    check("busy_after_req", n, 3);

`ifdef PIPE_CTRL_PERF_EN
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("perf_stall4", bus.stall_cnt, 32'd4);
    check("perf_flush1", bus.flush_cnt, 32'd1);
`endif

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 5) == 0),
           1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset in the middle of a divide.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", 32'(got()), 32'(12'b111110000000));
`ifdef PIPE_CTRL_PERF_EN
    check("async_reset_stall_cnt", bus.stall_cnt, 32'd0);
    check("async_reset_flush_cnt", bus.flush_cnt, 32'd0);
`endif
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    model_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the five-stage MIPS CPU.
- Generates the enable and synchronous-clear strobes for PC, F_D, D_E, E_M and M_W registers.
- Owns the multiply/divide busy timer and the eret redirect sequence.
- Arbitrates between hazard stalls, MDU stalls, eret flush and exception request (Req); Req has the highest priority.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, width of the MDU countdown; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- hz_stall  in  1  combinational data-hazard stall request from the hazard unit (D stage).
- D_md_use  in  1  instruction in D uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- E_md_start  in  1  instruction in E starts the MDU this cycle.
- E_md_div  in  1  qualifies E_md_start: 1 = div class, 0 = mult class.
- D_eret  in  1  eret is in D.
- Req  in  1  exception/interrupt taken at M (from CP0).
- PC_en  out  1  PC write enable.
- FD_en, DE_en, EM_en, MW_en  out  1 each  pipeline register enables.
- FD_reset, DE_reset, EM_reset, MW_reset  out  1 each  synchronous clear into a bubble.
- npc_epc  out  1  select EPC as next PC.
- md_busy  out  1  MDU countdown nonzero.
- eret_state  out  1  0 = RUN, 1 = ERET_FLUSH.

Behaviour:
- Reset (reset=0, async): md_cnt=0, state=RUN, md_busy=0, eret_state=0.
  - While held in reset, all enables=1 and all *_reset=0.
- MDU timer:
  - On a rising edge with E_md_start=1 and Req=0, md_cnt loads DIV_CYCLES if E_md_div else MULT_CYCLES.
  - Otherwise, if md_cnt!=0, md_cnt decrements by 1.
  - md_busy = (md_cnt!=0). A start at edge t gives md_busy=1 for exactly N cycles.
  - A start while md_cnt!=0 cannot occur (stall prevents it). If it does, the timer reloads.
  - Req does not abort a running count (HI/LO commit is already decided). Req does block a same-cycle start.
- Stall decision (combinational): stall = hz_stall | (D_md_use & (md_busy | E_md_start)).
- Output priority, highest first:
  - Req=1: all enables=1; FD_reset, DE_reset, EM_reset, MW_reset=1; npc_epc=0; state forced to RUN on the next edge.
  - stall=1: PC_en=0, FD_en=0, DE_reset=1, DE_en=1, EM_en=1, MW_en=1; other resets=0.
    - An eret in D during stall waits; it is not consumed.
  - D_eret=1 & state=RUN: all enables=1, npc_epc=1; state goes to ERET_FLUSH at the next edge.
  - state=ERET_FLUSH: FD_reset=1 (discard the instruction fetched after eret), all enables=1; state goes to RUN.
  - Otherwise: all enables=1, all resets=0, npc_epc=0.
- The FSM has only two states, RUN and ERET_FLUSH. ERET_FLUSH always lasts exactly 1 cycle unless Req intervenes, which wins.
- Outputs other than md_busy/eret_state/perf are combinational from registered state plus inputs. There is no added latency.
- Mid-operation reset clears the timer and FSM immediately (asynchronous).

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0.
  - stall_cnt increments on each edge where stall=1 and Req=0.
  - flush_cnt increments on each edge where Req=1 or state=ERET_FLUSH.
  - Both counters wrap 0xFFFFFFFF to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then release with all inputs 0 → all enables=1, all resets=0, md_busy=0, npc_epc=0.
- E_md_start=1, E_md_div=0 for one cycle, then D_md_use=1 held → md_busy high for 5 cycles.
  - PC_en=0, FD_en=0, DE_reset=1 during the start cycle and the 5 busy cycles, then release.
  - Repeat with E_md_div=1 → busy for 10 cycles.
- D_eret=1 for one cycle → npc_epc=1 that cycle; the next cycle FD_reset=1 and eret_state=1; the cycle after, back to RUN.
- Req=1 coincident with E_md_start=1 and hz_stall=1 → all four *_reset=1, all enables=1, md_cnt stays 0.
- Req=1 while md_cnt=3 → count continues 2, 1, 0; and Req=1 during ERET_FLUSH → state returns to RUN.
- With PIPE_CTRL_PERF_EN defined: hz_stall=1 for 4 cycles, then one Req → stall_cnt=4, flush_cnt=1. Assert reset mid-run → both counters 0.
